// File: rtl/snake_master_sm_if.sv
// Control bundle between the snake master FSM and the rest of the game.
// master = the game controller, slave = the surrounding game logic and display.
interface snake_master_sm_if;
    logic       BTN_START;
    logic       TICK_1HZ;
    logic       SNAKE_EAT;
    logic       SNAKE_COLLIDE;
    logic [1:0] MSM_STATE;
    logic [3:0] SCORE;
    logic [5:0] TIME_LEFT;
    logic       GAME_RESTART;

    modport master (
        input  BTN_START,
        input  TICK_1HZ,
        input  SNAKE_EAT,
        input  SNAKE_COLLIDE,
        output MSM_STATE,
        output SCORE,
        output TIME_LEFT,
        output GAME_RESTART
    );

    modport slave (
        output BTN_START,
        output TICK_1HZ,
        output SNAKE_EAT,
        output SNAKE_COLLIDE,
        input  MSM_STATE,
        input  SCORE,
        input  TIME_LEFT,
        input  GAME_RESTART
    );
endinterface

// File: rtl/snake_master_sm.sv
// Snake game master FSM: debounced start button, IDLE/PLAY/LOSE/WIN sequencing,
// apple score and per-game time limit.
module snake_master_sm #(
    parameter int unsigned TARGET_SCORE = 10,
    parameter int unsigned DEBOUNCE_MAX = 999999,
    parameter int unsigned TIME_LIMIT   = 60
) (
    input  logic                CLK,
    input  logic                RESET,
    snake_master_sm_if.master   bus
);

    localparam int unsigned CNT_W      = (DEBOUNCE_MAX < 1) ? 1 : $clog2(DEBOUNCE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_MAX);
    localparam logic [3:0] SCORE_WIN   = 4'(TARGET_SCORE);
    localparam logic [3:0] SCORE_LAST  = 4'(TARGET_SCORE - 1);
    localparam logic [5:0] TIME_INIT   = 6'(TIME_LIMIT);
    localparam bit         HAS_LIMIT   = (TIME_LIMIT != 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_LOSE = 2'd2,
        ST_WIN  = 2'd3
    } state_e;

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    state_e           state_q, state_d;
    logic [3:0]       score_q, score_d;
    logic [5:0]       time_q, time_d;
    logic             restart_q, restart_d;
    logic             start_pulse;
    logic             won;

    always_comb begin
        sync1_d     = bus.BTN_START;
        sync2_d     = sync1_q;
        stable_d    = stable_q;
        cnt_d       = '0;
        state_d     = state_q;
        score_d     = score_q;
        time_d      = time_q;
        restart_d   = 1'b0;
        won         = 1'b0;

        // Count consecutive cycles of disagreement; a return to the stable level restarts it.
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_MAX) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        start_pulse = sync2_q && !stable_q && (cnt_q == CNT_MAX);

        case (state_q)
            ST_IDLE: begin
                score_d = '0;
                time_d  = TIME_INIT;
                if (start_pulse) begin
                    state_d   = ST_PLAY;
                    restart_d = 1'b1;
                end
            end
            ST_PLAY: begin
                if (bus.SNAKE_COLLIDE) begin
                    state_d = ST_LOSE;
                end else begin
                    if (bus.SNAKE_EAT) begin
                        if (score_q >= SCORE_LAST) begin
                            score_d = SCORE_WIN;
                            state_d = ST_WIN;
                            won     = 1'b1;
                        end else begin
                            score_d = score_q + 4'd1;
                        end
                    end
                    // A coincident tick still counts unless the eat just won the game.
                    if (bus.TICK_1HZ && HAS_LIMIT && !won && time_q != '0) begin
                        time_d = time_q - 6'd1;
                        if (time_q == 6'd1) begin
                            state_d = ST_LOSE;
                        end
                    end
                end
            end
            default: begin
                if (start_pulse) begin
                    state_d = ST_IDLE;
                    score_d = '0;
                    time_d  = TIME_INIT;
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            stable_q  <= 1'b0;
            cnt_q     <= '0;
            state_q   <= ST_IDLE;
            score_q   <= '0;
            time_q    <= TIME_INIT;
            restart_q <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            stable_q  <= stable_d;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            score_q   <= score_d;
            time_q    <= time_d;
            restart_q <= restart_d;
        end
    end

    assign bus.MSM_STATE    = state_q;
    assign bus.SCORE        = score_q;
    assign bus.TIME_LEFT    = time_q;
    assign bus.GAME_RESTART = restart_q;

endmodule
